// File: rtl/lcb_pkg.sv
// Shared definitions for the LCB request/response sequencer.
package lcb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_CHK,
    ST_TURN,
    ST_PRE,
    ST_REQ,
    ST_WAIT,
    ST_POST
  } lcb_state_t;

  localparam logic [7:0]  LCB_SYNC_BYTE = 8'hA5;

  localparam int unsigned ERR_CHK    = 0;
  localparam int unsigned ERR_BYTE_TO = 1;
  localparam int unsigned ERR_CMD    = 2;
  localparam int unsigned ERR_ACK_TO = 3;
  localparam int unsigned ERR_W      = 4;

  localparam int unsigned FRAME_W    = 3;

  function automatic int unsigned lcb_max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcb_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset.
module lcb_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lcb_frame_sched.sv
// LCB frame sequencer: parses SYNC/ADDR/CMD/CHK frames, times the RS485 turnaround,
// hands the transmitter a frame index and releases the bus after a guard time.
module lcb_frame_sched
  import lcb_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = LCB_SYNC_BYTE,
  parameter logic [7:0]  MY_ADDR   = 8'h01,
  parameter int unsigned N_FRAMES  = 8,
  parameter int unsigned TURN_CYC  = 400,
  parameter int unsigned GUARD_CYC = 80,
  parameter int unsigned BYTE_TO   = 8000,
  parameter int unsigned ACK_TO    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_busy,
  output logic               tx_rq,
  output logic [FRAME_W-1:0] frame_sel,
  output logic               dir_tx,
  output logic               dir_rx,
  output logic               sched_busy,
  output logic [ERR_W-1:0]   err_flags,
  input  logic               err_clr
);

  localparam int unsigned CNT_MAX =
    lcb_max2(lcb_max2(TURN_CYC, BYTE_TO), lcb_max2(ACK_TO, GUARD_CYC));
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(BYTE_TO - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TO - 1);

  lcb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       addr_q;
  logic [7:0]       cmd_q;
  logic [7:0]       chk_sum;
  logic             busy_s;
  logic             busy_q;
  logic             tx_done;

  lcb_sync2 #(.W(1)) u_busy_sync (
    .clk (clk),
    .rst (rst),
    .d   (tx_busy),
    .q   (busy_s)
  );

  assign tx_done    = busy_q & ~busy_s;
  assign chk_sum    = addr_q + cmd_q;
  assign sched_busy = (state != ST_IDLE);

  // cnt free-runs by default and every state change below re-clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      cmd_q     <= '0;
      busy_q    <= 1'b0;
      tx_rq     <= 1'b0;
      frame_sel <= '0;
      dir_tx    <= 1'b0;
      dir_rx    <= 1'b1;
      err_flags <= '0;
    end else begin
      busy_q <= busy_s;
      cnt    <= cnt + CNT_W'(1);
      // later bit sets override this clear, giving set priority
      if (err_clr) err_flags <= '0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_valid && rx_data == SYNC_BYTE) state <= ST_ADDR;
        end
        ST_ADDR, ST_CMD: begin
          if (rx_valid) begin
            cnt <= '0;
            if (state == ST_ADDR) begin
              addr_q <= rx_data;
              state  <= ST_CMD;
            end else begin
              cmd_q <= rx_data;
              state <= ST_CHK;
            end
          end else if (cnt == BYTE_LAST) begin
            err_flags[ERR_BYTE_TO] <= 1'b1;
            state                  <= ST_IDLE;
            cnt                    <= '0;
          end
        end
        ST_CHK: begin
          if (rx_valid) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (rx_data != chk_sum) begin
              err_flags[ERR_CHK] <= 1'b1;
            end else if (32'(cmd_q) >= N_FRAMES) begin
              err_flags[ERR_CMD] <= 1'b1;
            end else if (addr_q == MY_ADDR) begin
              frame_sel <= cmd_q[FRAME_W-1:0];
              state     <= ST_TURN;
            end
          end else if (cnt == BYTE_LAST) begin
            err_flags[ERR_BYTE_TO] <= 1'b1;
            state                  <= ST_IDLE;
            cnt                    <= '0;
          end
        end
        ST_TURN: begin
          if (cnt == TURN_LAST) begin
            dir_tx <= 1'b1;
            dir_rx <= 1'b0;
            state  <= ST_PRE;
            cnt    <= '0;
          end
        end
        ST_PRE: begin
          if (cnt == GUARD_LAST) begin
            tx_rq <= 1'b1;
            state <= ST_REQ;
            cnt   <= '0;
          end
        end
        ST_REQ: begin
          if (busy_s) begin
            tx_rq <= 1'b0;
            state <= ST_WAIT;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            err_flags[ERR_ACK_TO] <= 1'b1;
            tx_rq                 <= 1'b0;
            state                 <= ST_POST;
            cnt                   <= '0;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            state <= ST_POST;
            cnt   <= '0;
          end
        end
        ST_POST: begin
          if (cnt == GUARD_LAST) begin
            dir_tx <= 1'b0;
            dir_rx <= 1'b1;
            state  <= ST_IDLE;
            cnt    <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcb_frame_sched.sv
// Bench for lcb_frame_sched: frame table, timed handshake sequences, randomized frames.
module tb_lcb_frame_sched;

  localparam int         TURN_CYC  = 400;
  localparam int         GUARD_CYC = 80;
  localparam int         BYTE_TO   = 8000;
  localparam int         ACK_TO    = 1000;
  localparam int         N_FRAMES  = 8;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] MY_ADDR   = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_busy = 1'b0;
  logic       err_clr = 1'b0;
  logic       tx_rq, dir_tx, dir_rx, sched_busy;
  logic [2:0] frame_sel;
  logic [3:0] err_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  lcb_frame_sched #(
    .SYNC_BYTE (SYNC),
    .MY_ADDR   (MY_ADDR),
    .N_FRAMES  (N_FRAMES),
    .TURN_CYC  (TURN_CYC),
    .GUARD_CYC (GUARD_CYC),
    .BYTE_TO   (BYTE_TO),
    .ACK_TO    (ACK_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_rq      (tx_rq),
    .frame_sel  (frame_sel),
    .dir_tx     (dir_tx),
    .dir_rx     (dir_rx),
    .sched_busy (sched_busy),
    .err_flags  (err_flags),
    .err_clr    (err_clr)
  );

  typedef struct {
    logic [7:0] a, c, k;
    bit         answer;
    logic [3:0] err;
    logic [2:0] sel;
  } vec_t;

  typedef struct packed {
    logic       answer;
    logic [3:0] err;
    logic [2:0] sel;
  } res_t;

  // Outcome of one complete frame, straight from the frame acceptance rules.
  function automatic res_t ref_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] k);
    res_t r;
    int   sum;
    r   = '0;
    sum = (int'(a) + int'(c)) % 256;
    if (sum != int'(k))           r.err[0] = 1'b1;
    else if (int'(c) >= N_FRAMES) r.err[2] = 1'b1;
    else if (a == MY_ADDR) begin
      r.answer = 1'b1;
      r.sel    = c[2:0];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] k, input int gap);
    send_byte(SYNC);
    repeat (gap) @(negedge clk);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(c);
    repeat (gap) @(negedge clk);
    send_byte(k);
  endtask

  task automatic strobe_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // n0 = posedges already elapsed since the CHK byte was sampled (inclusive).
  task automatic reach_rq(input logic [2:0] sel, input int n0, input string tag);
    int n;
    n = n0;
    while (dir_tx !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check({tag, " dir_tx latency"}, n, TURN_CYC + 1);
    check({tag, " dir_rx low"}, dir_rx, 0);
    n = 0;
    while (tx_rq !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check({tag, " tx_rq latency"}, n, GUARD_CYC);
    check({tag, " frame_sel"}, frame_sel, sel);
    check({tag, " busy in REQ"}, sched_busy, 1);
  endtask

  task automatic run_answer(input logic [2:0] sel, input int n0, input int busy_len,
                            input bit ack, input string tag);
    int n;
    reach_rq(sel, n0, tag);
    if (ack) begin
      repeat (30) @(negedge clk);
      check({tag, " tx_rq held"}, tx_rq, 1);
      tx_busy = 1'b1;
      n = 0;
      while (tx_rq === 1'b1 && n < 3000) begin @(negedge clk); n++; end
      // two synchroniser stages, then tx_rq drops one clock after busy_s
      check({tag, " tx_rq drop"}, n, 3);
      repeat (busy_len - 3) @(negedge clk);
      check({tag, " dir_tx during tx"}, dir_tx, 1);
      tx_busy = 1'b0;
      n = 0;
      while (dir_tx === 1'b1 && n < 5000) begin @(negedge clk); n++; end
      // two synchroniser stages, one to see the busy_s fall, then the guard
      check({tag, " dir_tx release"}, n, 3 + GUARD_CYC);
    end else begin
      n = 0;
      while (tx_rq === 1'b1 && n < 5000) begin @(negedge clk); n++; end
      check({tag, " ack timeout"}, n, ACK_TO);
      check({tag, " err ack"}, err_flags[3], 1);
      check({tag, " dir_tx in post"}, dir_tx, 1);
      n = 0;
      while (dir_tx === 1'b1 && n < 5000) begin @(negedge clk); n++; end
      check({tag, " post guard"}, n, GUARD_CYC);
    end
    check({tag, " dir_rx back"}, dir_rx, 1);
    check({tag, " idle"}, sched_busy, 0);
  endtask

  vec_t       tbl[10];
  res_t       r;
  logic [3:0] exp_err;
  logic [7:0] a, c, k, nb;

  initial begin
    tbl[0] = '{8'h01, 8'h03, 8'h04, 1'b1, 4'b0000, 3'd3};
    tbl[1] = '{8'h01, 8'h03, 8'h05, 1'b0, 4'b0001, 3'd0};
    tbl[2] = '{8'h02, 8'h03, 8'h05, 1'b0, 4'b0000, 3'd0};
    tbl[3] = '{8'h01, 8'h09, 8'h0A, 1'b0, 4'b0100, 3'd0};
    tbl[4] = '{8'hFF, 8'h02, 8'h01, 1'b0, 4'b0000, 3'd0};
    tbl[5] = '{8'h01, 8'h07, 8'h08, 1'b1, 4'b0000, 3'd7};
    tbl[6] = '{8'h01, 8'h08, 8'h09, 1'b0, 4'b0100, 3'd0};
    tbl[7] = '{8'h01, 8'h00, 8'h01, 1'b1, 4'b0000, 3'd0};
    tbl[8] = '{8'h01, 8'h02, 8'hA5, 1'b0, 4'b0001, 3'd0};
    tbl[9] = '{8'hA5, 8'h5C, 8'h01, 1'b0, 4'b0100, 3'd0};

    repeat (3) @(negedge clk);
    check("reset tx_rq", tx_rq, 0);
    check("reset dir_tx", dir_tx, 0);
    check("reset dir_rx", dir_rx, 1);
    check("reset sched_busy", sched_busy, 0);
    check("reset err_flags", err_flags, 0);
    check("reset frame_sel", frame_sel, 0);
    rst = 1'b1;
    @(negedge clk);

    // Valid frame with a long transmission
    send_frame(8'h01, 8'h03, 8'h04, 0);
    run_answer(3'd3, 1, 2000, 1'b1, "t2");

    for (int i = 0; i < 10; i++) begin
      strobe_clr();
      check($sformatf("tbl%0d clr", i), err_flags, 0);
      send_frame(tbl[i].a, tbl[i].c, tbl[i].k, i % 3);
      check($sformatf("tbl%0d err", i), err_flags, tbl[i].err);
      if (tbl[i].answer) begin
        run_answer(tbl[i].sel, 1, 120, 1'b1, $sformatf("tbl%0d", i));
      end else begin
        check($sformatf("tbl%0d idle", i), sched_busy, 0);
        check($sformatf("tbl%0d no dir_tx", i), dir_tx, 0);
      end
    end

    // Inter-byte timeout boundary, then a foreign-address frame stays silent
    strobe_clr();
    send_byte(SYNC);
    send_byte(8'h01);
    repeat (BYTE_TO - 1) @(negedge clk);
    check("byte_to before", err_flags[1], 0);
    check("byte_to busy before", sched_busy, 1);
    @(negedge clk);
    check("byte_to flag", err_flags[1], 1);
    check("byte_to idle", sched_busy, 0);
    send_frame(8'h02, 8'h03, 8'h05, 0);
    check("foreign err", err_flags, 4'b0010);
    check("foreign idle", sched_busy, 0);

    // Transmitter never answers
    strobe_clr();
    send_frame(8'h01, 8'h04, 8'h05, 1);
    run_answer(3'd4, 1, 0, 1'b0, "noack");
    check("noack flags", err_flags, 4'b1000);

    // Set wins over a clear strobe in the same cycle
    strobe_clr();
    send_frame(8'h01, 8'h09, 8'h0A, 0);
    check("pre prio", err_flags, 4'b0100);
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h03);
    rx_valid = 1'b1;
    rx_data  = 8'h05;
    err_clr  = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    err_clr  = 1'b0;
    check("set priority", err_flags, 4'b0001);
    strobe_clr();
    check("clear", err_flags, 0);

    // Bytes arriving during TURN are ignored and not queued
    send_frame(8'h01, 8'h02, 8'h03, 0);
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h04);
    run_answer(3'd2, 5, 150, 1'b1, "echo");
    repeat (20) @(negedge clk);
    check("echo no requeue", sched_busy, 0);
    check("echo no dir_tx", dir_tx, 0);

    // Asynchronous reset while requesting
    send_frame(8'h01, 8'h05, 8'h06, 0);
    reach_rq(3'd5, 1, "rst_req");
    #2 rst = 1'b0;
    #1;
    check("rst_req tx_rq", tx_rq, 0);
    check("rst_req dir_tx", dir_tx, 0);
    check("rst_req dir_rx", dir_rx, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Asynchronous reset during WAIT
    send_frame(8'h01, 8'h06, 8'h07, 1);
    reach_rq(3'd6, 1, "rst_wait");
    tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_wait in wait", tx_rq, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_wait dir_tx", dir_tx, 0);
    check("rst_wait dir_rx", dir_rx, 1);
    check("rst_wait busy", sched_busy, 0);
    check("rst_wait frame_sel", frame_sel, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Randomized frames against the rule model with sticky error accumulation
    strobe_clr();
    exp_err = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == SYNC) nb = 8'h5A;
        send_byte(nb);
      end
      check($sformatf("rnd%0d noise", i), sched_busy, 0);
      if ($urandom_range(0, 3) == 0) begin
        strobe_clr();
        exp_err = '0;
      end
      case ($urandom_range(0, 3))
        0:       a = 8'hFF;
        1:       a = 8'($urandom_range(0, 255));
        default: a = MY_ADDR;
      endcase
      c = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(a + c);
      send_frame(a, c, k, int'($urandom_range(0, 2)));
      r       = ref_frame(a, c, k);
      exp_err = exp_err | r.err;
      check($sformatf("rnd%0d err", i), err_flags, exp_err);
      if (r.answer) begin
        run_answer(r.sel, 1, int'($urandom_range(50, 200)), 1'b1, $sformatf("rnd%0d", i));
      end else begin
        check($sformatf("rnd%0d idle", i), sched_busy, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
